// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the ID/EX/MEM datapath and the pipeline hazard controller.
// The datapath side (master) raises requests; the controller side (slave) returns holds and flushes.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_reg1_read;
  logic [4:0]       id_reg1_addr;
  logic             id_reg2_read;
  logic [4:0]       id_reg2_addr;
  logic             ex_is_load;
  logic             ex_wreg;
  logic [4:0]       ex_wd;
  logic             ex_mc_req;
  logic             mem_stall_req;
  logic             flush_req;
  logic [31:0]      flush_pc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             ex_mc_done;
  logic             ex_mc_cancel;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
    output ex_is_load, ex_wreg, ex_wd, ex_mc_req,
    output mem_stall_req, flush_req, flush_pc,
    input  stall, flush, new_pc, ex_mc_done, ex_mc_cancel, stall_cycles
  );

  modport slave (
    input  id_reg1_read, id_reg1_addr, id_reg2_read, id_reg2_addr,
    input  ex_is_load, ex_wreg, ex_wd, ex_mc_req,
    input  mem_stall_req, flush_req, flush_pc,
    output stall, flush, new_pc, ex_mc_done, ex_mc_cancel, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller for the 5-stage core: load-use bubbles,
// multi-cycle EX ops, memory wait, redirect flushes and a saturating stall counter.
module pipe_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam int MC_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;

  localparam logic [5:0] STALL_ALL  = 6'b111111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [MC_W-1:0]  mc_cnt_reg;
  logic             flush_reg;
  logic [31:0]      new_pc_reg;
  logic             cancel_reg;
  logic [CNT_W-1:0] stall_cycles_reg;

  logic [5:0]       stall_next;
  logic             done_next;
  logic             mc_zero;
  logic             load_use;

  logic [1:0]       src_read;
  logic [4:0]       src_addr [2];
  logic [1:0]       src_hit;

  assign src_read    = {bus.id_reg2_read, bus.id_reg1_read};
  assign src_addr[0] = bus.id_reg1_addr;
  assign src_addr[1] = bus.id_reg2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_read[gi] && (src_addr[gi] == bus.ex_wd);
    end
  endgenerate

  // r0 is hardwired to zero, so a load targeting it can never feed a stale value.
  assign load_use = bus.ex_is_load && bus.ex_wreg && (bus.ex_wd != 5'd0) && (|src_hit);
  assign mc_zero  = (mc_cnt_reg == '0);

  always_comb begin
    stall_next = 6'b000000;
    done_next  = 1'b0;
    if (rst) begin
      stall_next = 6'b000000;
    end else if (bus.flush_req) begin
      stall_next = STALL_ALL;
    end else if (state_reg == FLUSH) begin
      stall_next = 6'b000000;
    end else if (bus.mem_stall_req) begin
      stall_next = STALL_MEM;
    end else if (state_reg == MC_BUSY && !mc_zero) begin
      stall_next = STALL_MC;
    end else if (state_reg == IDLE && bus.ex_mc_req) begin
      stall_next = STALL_MC;
    end else begin
      // Either plain IDLE or the MC done cycle: only a load-use bubble can hold.
      done_next  = (state_reg == MC_BUSY);
      stall_next = load_use ? STALL_LU : 6'b000000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      mc_cnt_reg       <= '0;
      flush_reg        <= 1'b0;
      new_pc_reg       <= 32'd0;
      cancel_reg       <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      flush_reg  <= bus.flush_req;
      cancel_reg <= bus.flush_req && (state_reg == MC_BUSY);
      if (bus.flush_req)
        new_pc_reg <= bus.flush_pc;
      if (stall_next[0] && (stall_cycles_reg != {CNT_W{1'b1}}))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;

      if (bus.flush_req) begin
        state_reg <= FLUSH;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!bus.mem_stall_req && bus.ex_mc_req) begin
              state_reg  <= MC_BUSY;
              mc_cnt_reg <= MC_W'(MC_LATENCY - 1);
            end
          end
          MC_BUSY: begin
            // Memory wait freezes the countdown so the result lines up with MEM.
            if (!bus.mem_stall_req) begin
              if (mc_zero)
                state_reg <= IDLE;
              else
                mc_cnt_reg <= mc_cnt_reg - 1'b1;
            end
          end
          FLUSH: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.stall        = stall_next;
  assign bus.ex_mc_done   = done_next;
  assign bus.flush        = flush_reg;
  assign bus.new_pc       = new_pc_reg;
  assign bus.ex_mc_cancel = cancel_reg;
  assign bus.stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expected outputs are queued by the stimulus
// and checked by an independent negedge monitor.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.MC_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        cancel;
    logic [3:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         vec_id = 0;
  logic [3:0] cnt_model = 4'd0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  task automatic clear_inputs();
    rst               = 1'b0;
    bus.id_reg1_read  = 1'b0;
    bus.id_reg1_addr  = 5'd0;
    bus.id_reg2_read  = 1'b0;
    bus.id_reg2_addr  = 5'd0;
    bus.ex_is_load    = 1'b0;
    bus.ex_wreg       = 1'b0;
    bus.ex_wd         = 5'd0;
    bus.ex_mc_req     = 1'b0;
    bus.mem_stall_req = 1'b0;
    bus.flush_req     = 1'b0;
    bus.flush_pc      = 32'd0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic lu(input logic [4:0] wd, input logic r1rd, input logic [4:0] r1a,
                    input logic r2rd, input logic [4:0] r2a);
    bus.ex_is_load   = 1'b1;
    bus.ex_wreg      = 1'b1;
    bus.ex_wd        = wd;
    bus.id_reg1_read = r1rd;
    bus.id_reg1_addr = r1a;
    bus.id_reg2_read = r2rd;
    bus.id_reg2_addr = r2a;
  endtask

  task automatic fl(input logic [31:0] pc);
    bus.flush_req = 1'b1;
    bus.flush_pc  = pc;
  endtask

  // Queue what the outputs must look like in the current cycle.
  task automatic exp_out(input logic [5:0] s, input logic f, input logic [31:0] p,
                         input logic d, input logic c);
    exp_t e;
    e.id = vec_id; e.stall = s; e.flush = f; e.pc = p; e.done = d; e.cancel = c;
    e.cnt = cnt_model;
    sb.push_back(e);
    vec_id++;
    if (s[0] && cnt_model != 4'hF)
      cnt_model = cnt_model + 4'd1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall",  e.id, 32'(bus.stall),        32'(e.stall));
      chk("flush",  e.id, 32'(bus.flush),        32'(e.flush));
      chk("new_pc", e.id, bus.new_pc,            e.pc);
      chk("done",   e.id, 32'(bus.ex_mc_done),   32'(e.done));
      chk("cancel", e.id, 32'(bus.ex_mc_cancel), 32'(e.cancel));
      chk("cnt",    e.id, 32'(bus.stall_cycles), 32'(e.cnt));
      $display("vec%0d stall=%b flush=%b pc=%h done=%b cancel=%b cnt=%0d",
               e.id, bus.stall, bus.flush, bus.new_pc, bus.ex_mc_done,
               bus.ex_mc_cancel, bus.stall_cycles);
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state and load-use hazards
    nxt();                         exp_out(6'b000000, 0, 32'h0, 0, 0);
    nxt(); lu(5'd3, 1, 5'd3, 0, 5'd0); exp_out(6'b000111, 0, 32'h0, 0, 0);
    nxt(); lu(5'd0, 1, 5'd0, 0, 5'd0); exp_out(6'b000000, 0, 32'h0, 0, 0);
    nxt(); lu(5'd5, 0, 5'd1, 1, 5'd5); exp_out(6'b000111, 0, 32'h0, 0, 0);
    nxt(); lu(5'd5, 0, 5'd5, 0, 5'd5); exp_out(6'b000000, 0, 32'h0, 0, 0);
    nxt(); lu(5'd5, 1, 5'd5, 0, 5'd0); bus.ex_wreg = 1'b0;
                                   exp_out(6'b000000, 0, 32'h0, 0, 0);

    // Multi-cycle op: stall cycles 0..3, done in cycle 4, no restart after
    for (int i = 0; i < 4; i++) begin
      nxt(); bus.ex_mc_req = 1'b1; exp_out(6'b001111, 0, 32'h0, 0, 0);
    end
    nxt(); bus.ex_mc_req = 1'b1;   exp_out(6'b000000, 0, 32'h0, 1, 0);
    nxt();                         exp_out(6'b000000, 0, 32'h0, 0, 0);

    // Memory wait in MC_BUSY delays done by two cycles
    nxt(); bus.ex_mc_req = 1'b1;   exp_out(6'b001111, 0, 32'h0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      nxt(); bus.ex_mc_req = 1'b1; bus.mem_stall_req = 1'b1;
      exp_out(6'b011111, 0, 32'h0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      nxt(); bus.ex_mc_req = 1'b1; exp_out(6'b001111, 0, 32'h0, 0, 0);
    end
    nxt(); bus.ex_mc_req = 1'b1;   exp_out(6'b000000, 0, 32'h0, 1, 0);

    // Flush during MC_BUSY cancels the op
    nxt(); bus.ex_mc_req = 1'b1;   exp_out(6'b001111, 0, 32'h0, 0, 0);
    nxt(); bus.ex_mc_req = 1'b1; fl(32'hBFC00380);
                                   exp_out(6'b111111, 0, 32'h0, 0, 0);
    nxt();                         exp_out(6'b000000, 1, 32'hBFC00380, 0, 1);
    nxt();                         exp_out(6'b000000, 0, 32'hBFC00380, 0, 0);

    // Flush wins over a simultaneous multi-cycle request: no MC_BUSY, no cancel
    nxt(); bus.ex_mc_req = 1'b1; fl(32'h80000180);
                                   exp_out(6'b111111, 0, 32'hBFC00380, 0, 0);
    nxt();                         exp_out(6'b000000, 1, 32'h80000180, 0, 0);
    nxt();                         exp_out(6'b000000, 0, 32'h80000180, 0, 0);

    // Back-to-back flush re-latches the PC; stall counter saturates at 15
    nxt(); fl(32'h00001000);       exp_out(6'b111111, 0, 32'h80000180, 0, 0);
    nxt(); fl(32'h00002000);       exp_out(6'b111111, 1, 32'h00001000, 0, 0);
    nxt();                         exp_out(6'b000000, 1, 32'h00002000, 0, 0);
    nxt();                         exp_out(6'b000000, 0, 32'h00002000, 0, 0);

    // Memory wait outranks load-use in IDLE
    nxt(); bus.mem_stall_req = 1'b1; lu(5'd7, 1, 5'd7, 0, 5'd0);
                                   exp_out(6'b011111, 0, 32'h00002000, 0, 0);
    nxt();                         exp_out(6'b000000, 0, 32'h00002000, 0, 0);

    // Done cycle falls back to the load-use rule
    for (int i = 0; i < 4; i++) begin
      nxt(); bus.ex_mc_req = 1'b1; exp_out(6'b001111, 0, 32'h00002000, 0, 0);
    end
    nxt(); bus.ex_mc_req = 1'b1; lu(5'd9, 0, 5'd0, 1, 5'd9);
                                   exp_out(6'b000111, 0, 32'h00002000, 1, 0);
    nxt();                         exp_out(6'b000000, 0, 32'h00002000, 0, 0);

    // Reset mid-op aborts silently
    nxt(); bus.ex_mc_req = 1'b1;   exp_out(6'b001111, 0, 32'h00002000, 0, 0);
    nxt(); bus.ex_mc_req = 1'b1;   exp_out(6'b001111, 0, 32'h00002000, 0, 0);
    nxt(); bus.ex_mc_req = 1'b1; rst = 1'b1;
    cnt_model = 4'd0;
    nxt();                         exp_out(6'b000000, 0, 32'h0, 0, 0);
    nxt();                         exp_out(6'b000000, 0, 32'h0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
